div_sign_sequencer: RTL and testbench
=====================================

# div_sign_sequencer

Front-end sequencer that sits directly upstream of the multi-cycle `unpipelined_divider`, and also consumes its results. It accepts one signed or unsigned division request over a valid/ready handshake. It converts signed operands to magnitudes, launches the divider with a one-cycle `start` pulse and holds its operand inputs stable until `done`. It then applies sign correction, handles divide-by-zero without invoking the divider, and presents the result over a valid/ready output handshake.

## Interface
- `N`, default 32: operand/result width; must match the divider's `N`.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high. Shared with the divider.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_signed` in 1: 1 = two's-complement operation, 0 = unsigned.
- `in_dividend` in N: dividend.
- `in_divisor` in N: divisor.
- `div_start` out 1: drives the divider's `start`.
- `div_dividend` out N: drives the divider's `dividend` (magnitude).
- `div_divisor` out N: drives the divider's `divisor` (magnitude).
- `div_quotient` in N: divider's `quotient`.
- `div_remainder` in N: divider's `remainder`.
- `div_done` in 1: divider's `done`.
- `out_valid` out 1: result valid; held until `out_ready`.
- `out_ready` in 1: downstream accepts the result.
- `out_quotient` out N: final quotient.
- `out_remainder` out N: final remainder.
- `out_div_by_zero` out 1: divisor was 0.
- `out_overflow` out 1: signed `MIN / -1`.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- `in_ready = (state == IDLE)`. Only one request is outstanding at a time.
- IDLE, on handshake, registers the following:
  - `neg_q = in_signed & (dividend[N-1] ^ divisor[N-1])`
  - `neg_r = in_signed & dividend[N-1]`
  - magnitudes: `|x| = (in_signed & x[N-1]) ? -x : x`, modulo 2^N, so `|MIN| = 2^(N-1)` as unsigned
  - the raw dividend
  - `ovf = in_signed & dividend==MIN & divisor=={N{1}}`
- IDLE transitions:
  - If divisor == 0, go to RESP with quotient = {N{1}}, remainder = raw dividend, `out_div_by_zero = 1`. The divider is not started.
  - Otherwise go to LAUNCH.
- LAUNCH: `div_start = 1` for exactly this one cycle, then go to WAIT.
- `div_dividend`/`div_divisor` are registered magnitudes. They are stable from LAUNCH through the `div_done` cycle, because the divider samples them in the cycle after `start`.
- WAIT: on `div_done = 1`, capture the results and go to RESP:
  - `out_quotient = neg_q ? -div_quotient : div_quotient`
  - `out_remainder = neg_r ? -div_remainder : div_remainder`
  - All arithmetic is modulo 2^N.
- RESP: `out_valid = 1`. When `out_ready = 1`, go to IDLE. `out_*` stay stable while `out_valid && !out_ready`.
- `out_overflow = ovf`. The result falls out of the magnitude path with no special case: quotient = MIN, remainder = 0.
- `div_done` outside WAIT is ignored. `div_start` is never asserted outside LAUNCH.

## Timing
- Reset values:
  - state IDLE
  - `in_ready = 1`
  - `div_start = 0`, `div_dividend = 0`, `div_divisor = 0`
  - `out_valid = 0`, `out_quotient = 0`, `out_remainder = 0`
  - `out_div_by_zero = 0`, `out_overflow = 0`
- Normal path, with accept handshake at cycle 0:
  - `div_start` is high in cycle 1.
  - `out_valid` is high starting the cycle after `div_done` is sampled high.
  - With the current divider, end-to-end latency is N+5 cycles.
- Divide-by-zero path: `out_valid` is high at cycle 1.
- Throughput: at least one cycle of IDLE (`in_ready = 1`) separates the output handshake from the next accept. There is no same-cycle re-accept.
- Reset asserted in any state immediately returns all outputs to their reset values. Any in-flight operation is discarded, and no stale `div_done` is forwarded afterwards.

## Test plan
- Unsigned 100 / 7:
  - `div_start` pulses exactly once with `div_dividend = 100`, `div_divisor = 7`.
  - Result: quotient 14, remainder 2, both flags 0.
- Signed sign combinations:
  - -7 / 2: divider sees 7 / 2; result quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7 / -2: quotient 0xFFFFFFFD, remainder 1.
  - -7 / -2: quotient 3, remainder 0xFFFFFFFF.
- Divide by zero, 0x12345678 / 0 (signed and unsigned):
  - Result: quotient 0xFFFFFFFF, remainder 0x12345678, `out_div_by_zero = 1`.
  - `out_valid` is high one cycle after accept; `div_start` never asserts.
- Overflow, 0x80000000 / 0xFFFFFFFF:
  - Signed: quotient 0x80000000, remainder 0, `out_overflow = 1`.
  - Unsigned: quotient 0, remainder 0x80000000, `out_overflow = 0`.
- Backpressure: hold `out_ready = 0` for 10 cycles after `out_valid`.
  - Outputs and flags stay stable, and `in_ready` stays 0.
  - Release `out_ready`: one handshake occurs, then `in_ready = 1` the next cycle.
- Reset mid-operation: assert `rst` during WAIT.
  - All outputs take their reset values.
  - A new request afterwards (20 / 6) returns quotient 3, remainder 2 with no stale result emitted.

Source files
------------

// File: rtl/div_sign_sequencer.sv
// Signed/unsigned front end for the iterative unpipelined divider: strips operand
// signs, launches the divider, restores result signs and flags div-by-zero / MIN/-1.
module div_sign_sequencer #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_signed,
   input  logic [N-1:0] in_dividend,
   input  logic [N-1:0] in_divisor,
   output logic         div_start,
   output logic [N-1:0] div_dividend,
   output logic [N-1:0] div_divisor,
   input  logic [N-1:0] div_quotient,
   input  logic [N-1:0] div_remainder,
   input  logic         div_done,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_quotient,
   output logic [N-1:0] out_remainder,
   output logic         out_div_by_zero,
   output logic         out_overflow
);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

   localparam logic [N-1:0]        ONE       = {{(N-1){1'b0}}, 1'b1};
   localparam logic signed [N-1:0] ZERO_S    = '0;
   localparam logic signed [N-1:0] MINUS_ONE = '1;
   localparam logic signed [N-1:0] MIN_S     = {1'b1, {(N-1){1'b0}}};

   state_t state, state_nxt;

   logic signed [N-1:0] dividend_s;
   logic signed [N-1:0] divisor_s;
   logic                accept;
   logic                dvs_zero;
   logic                neg_q_c;
   logic                neg_r_c;
   logic                ovf_c;
   logic                neg_q;
   logic                neg_r;

   // Two's-complement negation, modulo 2^N.
   function automatic logic [N-1:0] negate(input logic [N-1:0] x);
      return ~x + ONE;
   endfunction

   // |MIN| wraps to 2^(N-1), which is exactly the unsigned magnitude the divider needs.
   function automatic logic [N-1:0] magnitude(input logic is_signed, input logic [N-1:0] x);
      return (is_signed && x[N-1]) ? negate(x) : x;
   endfunction

   function automatic logic [N-1:0] apply_sign(input logic neg, input logic [N-1:0] x);
      return neg ? negate(x) : x;
   endfunction

   assign dividend_s = $signed(in_dividend);
   assign divisor_s  = $signed(in_divisor);
   assign accept     = in_valid && in_ready;
   assign dvs_zero   = (in_divisor == '0);
   assign neg_q_c    = in_signed && ((dividend_s < ZERO_S) != (divisor_s < ZERO_S));
   assign neg_r_c    = in_signed && (dividend_s < ZERO_S);
   assign ovf_c      = in_signed && (dividend_s == MIN_S) && (divisor_s == MINUS_ONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      div_start = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = dvs_zero ? RESP : LAUNCH;
            end
         end
         LAUNCH: begin
            div_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (div_done) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Accept stage: capture signs, magnitudes and flags; divide-by-zero resolves here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_q           <= 1'b0;
         neg_r           <= 1'b0;
         div_dividend    <= '0;
         div_divisor     <= '0;
         out_div_by_zero <= 1'b0;
         out_overflow    <= 1'b0;
      end else if (accept) begin
         neg_q           <= neg_q_c;
         neg_r           <= neg_r_c;
         div_dividend    <= magnitude(in_signed, in_dividend);
         div_divisor     <= magnitude(in_signed, in_divisor);
         out_div_by_zero <= dvs_zero;
         out_overflow    <= ovf_c;
      end
   end

   // Result stage: sign-correct divider results; only a done seen in WAIT is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_quotient  <= '0;
         out_remainder <= '0;
      end else if (accept && dvs_zero) begin
         out_quotient  <= '1;
         out_remainder <= in_dividend;
      end else if (state == WAIT && div_done) begin
         out_quotient  <= apply_sign(neg_q, div_quotient);
         out_remainder <= apply_sign(neg_r, div_remainder);
      end
   end

endmodule

// File: tb/tb_div_sign_sequencer.sv
// Randomized bench for div_sign_sequencer with a behavioural divider and reference model.
module tb_div_sign_sequencer;
   localparam int N = 32;
   localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, in_signed;
   logic [N-1:0] in_dividend, in_divisor;
   logic         div_start;
   logic [N-1:0] div_dividend, div_divisor, div_quotient, div_remainder;
   logic         div_done;
   logic         out_valid, out_ready;
   logic [N-1:0] out_quotient, out_remainder;
   logic         out_div_by_zero, out_overflow;

   int n_chk = 0, n_pass = 0;
   int start_count = 0, stab_err = 0;

   always #5 clk = ~clk;

   div_sign_sequencer #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
      .in_dividend(in_dividend), .in_divisor(in_divisor),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_quotient(out_quotient), .out_remainder(out_remainder),
      .out_div_by_zero(out_div_by_zero), .out_overflow(out_overflow)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural divider: samples operands the cycle after start, done N+3 cycles after
   // start. It ignores rst so that a reset mid-operation leaves a stale done in flight.
   initial begin : divider_model
      logic         busy;
      logic         poisoned;
      int           cnt;
      logic [N-1:0] cap_a, cap_b;
      busy = 1'b0; poisoned = 1'b0; cnt = 0; cap_a = '0; cap_b = '0;
      div_done = 1'b0; div_quotient = '0; div_remainder = '0;
      forever begin
         @(posedge clk);
         #2;
         div_done = 1'b0;
         if (rst && busy) poisoned = 1'b1;
         if (busy) begin
            cnt++;
            if (cnt == 1) begin
               cap_a = div_dividend;
               cap_b = div_divisor;
            end else if (!poisoned && (div_dividend !== cap_a || div_divisor !== cap_b)) begin
               stab_err++;
            end
            if (cnt == N + 3) begin
               div_done      = 1'b1;
               div_quotient  = (cap_b == '0) ? '1 : cap_a / cap_b;
               div_remainder = (cap_b == '0) ? cap_a : cap_a % cap_b;
               busy = 1'b0;
               poisoned = 1'b0;
            end
         end
         if (!rst && div_start) begin
            busy = 1'b1;
            cnt = 0;
            start_count++;
         end
      end
   end

   // Reference: truncating division on wide integers, results reduced modulo 2^N.
   function automatic void ref_div(input bit sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                                   output logic [N-1:0] q, output logic [N-1:0] r,
                                   output bit dz, output bit ov);
      longint sa, sb;
      dz = (b == '0);
      ov = sgn && (a == MIN) && (b == '1);
      if (dz) begin
         q = '1;
         r = a;
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = N'(sa / sb);
         r = N'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   function automatic logic [N-1:0] pick();
      logic [N-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = MIN;
         2:       v = '1;
         3:       v = N'($urandom_range(1, 20));
         4:       v = -N'($urandom_range(1, 20));
         default: v = N'($urandom);
      endcase
      return v;
   endfunction

   task automatic run_op(input bit sgn, input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
      logic [N-1:0] eq, er, q0, r0;
      bit           edz, eov, stable;
      logic         dz0, ov0;
      int           lat, s0, w;
      ref_div(sgn, a, b, eq, er, edz, eov);
      w = 0;
      while (!in_ready && w < 100) begin tick(); w++; end
      chk("in_ready_before_accept", 64'(in_ready), 64'(1));
      s0 = start_count;
      in_valid = 1'b1; in_signed = sgn; in_dividend = a; in_divisor = b;
      tick();
      in_valid = 1'b0; in_signed = 1'($urandom);
      in_dividend = N'($urandom); in_divisor = N'($urandom);
      chk("div_start_cycle1", 64'(div_start), edz ? 64'(0) : 64'(1));
      lat = 1;
      while (!out_valid && lat < 3 * N) begin tick(); lat++; end
      chk("latency", 64'(lat), edz ? 64'(1) : 64'(N + 5));
      chk("start_pulses", 64'(start_count - s0), edz ? 64'(0) : 64'(1));
      q0 = out_quotient; r0 = out_remainder; dz0 = out_div_by_zero; ov0 = out_overflow;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (!out_valid || in_ready || out_quotient !== q0 || out_remainder !== r0 ||
             out_div_by_zero !== dz0 || out_overflow !== ov0) stable = 1'b0;
      end
      chk("hold_stable", 64'(stable), 64'(1));
      chk("quotient", 64'(out_quotient), 64'(eq));
      chk("remainder", 64'(out_remainder), 64'(er));
      chk("div_by_zero", 64'(out_div_by_zero), 64'(edz));
      chk("overflow", 64'(out_overflow), 64'(eov));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_after_hs", 64'(out_valid), 64'(0));
      chk("in_ready_after_hs", 64'(in_ready), 64'(1));
   endtask

   initial begin
      int bad;
      rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_dividend = '0; in_divisor = '0;
      out_ready = 1'b0;
      tick(); tick();
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_div_start", 64'(div_start), 64'(0));
      chk("rst_outputs", {out_quotient, out_remainder}, 64'(0));
      chk("rst_flags", 64'({out_div_by_zero, out_overflow}), 64'(0));
      rst = 1'b0;
      tick();

      run_op(1'b0, 32'd100, 32'd7, 0);
      chk("launch_dividend", 64'(div_dividend), 64'(100));
      chk("launch_divisor", 64'(div_divisor), 64'(7));
      run_op(1'b1, -32'sd7, 32'd2, 1);
      chk("mag_dividend", 64'(div_dividend), 64'(7));
      run_op(1'b1, 32'd7, -32'sd2, 0);
      run_op(1'b1, -32'sd7, -32'sd2, 2);
      run_op(1'b1, 32'h1234_5678, 32'd0, 0);
      run_op(1'b0, 32'h1234_5678, 32'd0, 1);
      run_op(1'b1, MIN, 32'hFFFF_FFFF, 0);
      run_op(1'b0, MIN, 32'hFFFF_FFFF, 0);
      run_op(1'b0, 32'd12345, 32'd77, 10);

      for (int k = 0; k < 40; k++) begin
         run_op(1'($urandom), pick(), pick(), int'($urandom_range(0, 3)));
      end

      // Reset during WAIT, then let the stale done land while idle.
      in_valid = 1'b1; in_signed = 1'b0; in_dividend = 32'd1000; in_divisor = 32'd3;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      #3 rst = 1'b1;
      #1;
      chk("midrst_in_ready", 64'(in_ready), 64'(1));
      chk("midrst_div_start", 64'(div_start), 64'(0));
      chk("midrst_div_ops", {div_dividend, div_divisor}, 64'(0));
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_outputs", {out_quotient, out_remainder}, 64'(0));
      chk("midrst_flags", 64'({out_div_by_zero, out_overflow}), 64'(0));
      tick(); tick();
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < N + 8; i++) begin
         tick();
         if (out_valid || !in_ready) bad++;
      end
      chk("no_stale_result", 64'(bad), 64'(0));
      run_op(1'b0, 32'd20, 32'd6, 0);

      chk("operands_stable", 64'(stab_err), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
